// File: rtl/tone_seq_voice.sv
// tone_seq_voice: single-voice square-wave note sequencer.
// Accepts one note request at a time. It plays a square wave whose
// half-period comes from a note table shifted by an octave, for a set
// number of duration ticks. A silent gap follows, and then done pulses.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   note_valid/ready- request handshake (ready only in IDLE)
//   note, octave,dur- note index (0/15 rest), octave shift, length in ticks
//   abort           - abandon the current note without a done pulse
//   speaker         - registered square-wave output
//   busy, done      - playing/gapping flag, one-cycle completion pulse
module tone_seq_voice #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned CNT_W     = 18,
    parameter int unsigned DUR_W     = 10,
    parameter int unsigned TICK_CYC  = 100_000,
    parameter int unsigned GAP_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note,
    input  logic [1:0]       octave,
    input  logic [DUR_W-1:0] dur,
    input  logic             abort,
    output logic             speaker,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CYC_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int unsigned TK_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [63:0] CLK64 = 64'(CLK_HZ);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_CYC - 1);
    localparam logic [TK_W-1:0]  GAP_LAST = TK_W'(GAP_TICKS - 1);

    // Half-periods at 100 MHz; rescaled to CLK_HZ with rounding below.
    localparam logic [63:0] H100 [16] = '{
        64'd0,
        64'd191110, 64'd170265, 64'd151685, 64'd143172, 64'd127551,
        64'd113636, 64'd101239, 64'd95556,  64'd85131,  64'd75843,
        64'd71586,  64'd63776,  64'd56818,  64'd50619,
        64'd0
    };

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t           state, state_next;
    logic             done_next;
    logic [CNT_W-1:0] half_tab [16];
    logic [CNT_W-1:0] half_shift;
    logic             tone_in;
    logic [CNT_W-1:0] half;
    logic             tonal;
    logic [TK_W-1:0]  play_last;
    logic [CNT_W-1:0] phase;
    logic [CYC_W-1:0] cyc;
    logic [TK_W-1:0]  tick;
    logic             cyc_end, play_end, gap_end, toggle;

    // Constant half-period table for this clock frequency.
    for (genvar g = 0; g < 16; g++) begin : g_tab
        assign half_tab[g] = CNT_W'((H100[g] * CLK64 + 64'd50_000_000) / 64'd100_000_000);
    end

    assign half_shift = half_tab[note] >> octave;
    assign tone_in    = (note != 4'd0) && (note != 4'd15);
    assign cyc_end    = (cyc == CYC_LAST);
    assign play_end   = cyc_end && (tick == play_last);
    assign gap_end    = cyc_end && (tick == GAP_LAST);
    assign toggle     = (state == PLAY) && tonal && (phase == half - CNT_W'(1));

    // Next-state and done decode; abort overrides any end-of-note event.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (note_valid) state_next = PLAY;
            end
            PLAY: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (play_end) begin
                    if (GAP_TICKS == 0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, registered outputs, latched request and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
            note_ready <= 1'b1;
            speaker    <= 1'b0;
            half       <= '0;
            tonal      <= 1'b0;
            play_last  <= '0;
            phase      <= '0;
            cyc        <= '0;
            tick       <= '0;
        end else begin
            state      <= state_next;
            done       <= done_next;
            busy       <= (state_next != IDLE);
            note_ready <= (state_next == IDLE);

            if (state == IDLE && state_next == PLAY) begin
                tonal     <= tone_in;
                half      <= (half_shift == '0) ? CNT_W'(1) : half_shift;
                play_last <= (dur == '0) ? '0 : TK_W'(dur - DUR_W'(1));
                speaker   <= tone_in;
            end else if (state_next != PLAY) begin
                speaker <= 1'b0;
            end else if (toggle) begin
                speaker <= ~speaker;
            end

            // Counters restart on every state change, so they never wrap.
            if (state_next != state) begin
                cyc   <= '0;
                tick  <= '0;
                phase <= '0;
            end else if (state != IDLE) begin
                cyc <= cyc_end ? '0 : cyc + CYC_W'(1);
                if (cyc_end) tick <= tick + TK_W'(1);
                if (toggle) phase <= '0;
                else if (state == PLAY && tonal) phase <= phase + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/tone_seq_voice.md
TONE_SEQ_VOICE -- requirements
Module: tone_seq_voice

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: system clock frequency; sets the half-period table.
REQ-002 Parameter CNT_W, default 18: width of the half-period counter; must hold the largest table entry.
REQ-003 Parameter DUR_W, default 10: width of the note-duration field.
REQ-004 Parameter TICK_CYC, default 100_000: clock cycles per duration tick (1 ms at default CLK_HZ).
REQ-005 Parameter GAP_TICKS, default 10: silent articulation gap after each note, in ticks; 0 means no gap.
REQ-006 clk  in  1: single clock; all logic is on the rising edge.
REQ-007 reset  in  1: synchronous, active-high reset.
REQ-008 note_valid  in  1: a note request is present.
REQ-009 note_ready  out  1: the block can accept a request.
REQ-010 note  in  4: 1..14 selects C4,D4,E4,F4,G4,A4,B4,C5,D5,E5,F5,G5,A5,B5; 0 or 15 is a rest.
REQ-011 octave  in  2: upward octave shift, 0..3.
REQ-012 dur  in  DUR_W: note length in ticks.
REQ-013 abort  in  1: stop the current note immediately.
REQ-014 speaker  out  1: square-wave audio output.
REQ-015 busy  out  1: high in PLAY and GAP.
REQ-016 done  out  1: one-cycle pulse when a note and its gap complete.

Function
REQ-017 The block SHALL implement the states IDLE, PLAY and GAP.
REQ-018 note_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-019 A request is accepted on a rising edge where note_valid && note_ready; at that edge the block SHALL latch note, octave and dur and enter PLAY on the next cycle.
REQ-020 Inputs presented while busy SHALL be ignored; no queueing.
REQ-021 The half-period H is table[note] >> octave, where table[n] = round(CLK_HZ/(2*f_n)).
REQ-022 At CLK_HZ=100e6 the table SHALL be: 191110, 170265, 151685, 143172, 127551, 113636, 101239, 95556, 85131, 75843, 71586, 63776, 56818, 50619.
REQ-023 On entering PLAY with a tonal note, speaker SHALL be 1 for exactly H cycles and then 0 for exactly H cycles, repeating with a 50% duty cycle.
REQ-024 For a rest note, speaker SHALL stay 0 throughout PLAY.
REQ-025 PLAY SHALL last exactly max(dur,1)*TICK_CYC cycles.
REQ-026 After PLAY the block SHALL enter GAP, which lasts GAP_TICKS*TICK_CYC cycles with speaker=0; if GAP_TICKS=0, GAP is skipped.
REQ-027 On the cycle the block returns to IDLE from PLAY or GAP, done SHALL be 1 for exactly one cycle.
REQ-028 done and note_valid in the same cycle: the block SHALL accept the new request, giving back-to-back notes with no idle cycle.
REQ-029 abort high in PLAY or GAP: on the next cycle the block SHALL be in IDLE with speaker=0 and done=0; abort in IDLE has no effect.
REQ-030 abort and a note-end event in the same cycle: abort wins and done is not pulsed.
REQ-031 speaker SHALL be 0 in IDLE and SHALL be registered, with no glitches.
REQ-032 The phase and tick counters SHALL clear on entering PLAY and SHALL not wrap beyond their terminal counts.

Reset
REQ-033 While reset=1 the block SHALL hold state=IDLE, speaker=0, busy=0, done=0, note_ready=1, and all counters cleared.
REQ-034 Reset asserted mid-note SHALL abandon the note with no done pulse; a request on the first cycle after reset deasserts SHALL be accepted.

Verification
REQ-035 Tone: note=6, octave=0, dur=2, defaults -> speaker high 113636 cycles, then low 113636, repeating; busy for 200000 cycles of PLAY plus 1000000 cycles of GAP; done pulses once.
REQ-036 Octave: note=1, octave=3 -> half-period 23888 cycles; note=1, octave=0 -> 191110 cycles.
REQ-037 Rest and zero duration: note=0, dur=0, TICK_CYC=4, GAP_TICKS=0 -> speaker stays 0, PLAY lasts 4 cycles, done 4 cycles after PLAY entry.
REQ-038 Back-to-back: note_valid held high with TICK_CYC=4, GAP_TICKS=2 -> second note enters PLAY on the cycle after done with no gap cycle; note changes while busy are ignored.
REQ-039 Abort and reset: abort 50 cycles into PLAY -> IDLE next cycle, speaker=0, no done; reset mid-GAP -> outputs equal the REQ-033 values on the next cycle.
